// File: rtl/frac_clock_gen_pkg.sv
// Shared constants and helpers for the fractional clock-enable generator.
// Used by the RTL and by the bench to derive increments.
package frac_clk_pkg;
  localparam int ACC_W_DEF  = 16;
  localparam int NUM_CH_DEF = 4;

  function automatic logic [31:0] default_inc(input int acc_w);
    return 32'd1 << (acc_w - 1);
  endfunction

  // Increment giving an average tick rate of num/den of the clock.
  function automatic logic [31:0] inc_for_ratio(input int acc_w, input int num, input int den);
    logic [63:0] scaled;
    scaled = (64'(num) << acc_w) / 64'(den);
    return scaled[31:0];
  endfunction
endpackage

// File: rtl/frac_clock_gen_phase_acc.sv
// One phase-accumulator channel: acc, live increment, shadow increment and the
// deferred apply logic. Optional sync input under FRAC_CLOCK_GEN_PHASE_SYNC_EN.
module frac_phase_acc
  import frac_clk_pkg::*;
#(
  parameter int               ACC_W       = ACC_W_DEF,
  parameter logic [ACC_W-1:0] DEFAULT_INC = ACC_W'(default_inc(ACC_W))
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
`ifdef FRAC_CLOCK_GEN_PHASE_SYNC_EN
  input  logic             sync,
`endif
  input  logic             wr,
  input  logic [ACC_W-1:0] wr_inc,
  output logic             tick,
  output logic             clk_div,
  output logic             pending
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] shadow;
  logic [ACC_W:0]   sum;
  logic             clear;
  logic             apply;

  assign sum = {1'b0, acc} + {1'b0, inc};

`ifdef FRAC_CLOCK_GEN_PHASE_SYNC_EN
  assign clear = !en || sync;
`else
  assign clear = !en;
`endif

  // A zero increment or a cleared channel never overflows, so apply at once.
  assign apply = pending && (clear || sum[ACC_W] || (inc == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      inc     <= DEFAULT_INC;
      shadow  <= '0;
      pending <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (clear) begin
        acc  <= '0;
        tick <= 1'b0;
      end else begin
        {tick, acc} <= sum;
      end
      // wr is only ever raised while pending is low, so it never races apply.
      if (apply) begin
        inc     <= shadow;
        pending <= 1'b0;
      end else if (wr) begin
        shadow  <= wr_inc;
        pending <= 1'b1;
      end
    end
  end

  assign clk_div = acc[ACC_W-1];

endmodule

// File: rtl/frac_clock_gen.sv
// Multi-channel fractional clock-enable generator built on phase accumulators.
// Optional phase-sync input is enabled with FRAC_CLOCK_GEN_PHASE_SYNC_EN.
module frac_clock_gen
  import frac_clk_pkg::*;
#(
  parameter int               NUM_CH      = NUM_CH_DEF,
  parameter int               ACC_W       = ACC_W_DEF,
  parameter logic [ACC_W-1:0] DEFAULT_INC = ACC_W'(default_inc(ACC_W)),
  parameter int               CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] chan_en,
`ifdef FRAC_CLOCK_GEN_PHASE_SYNC_EN
  input  logic              sync,
`endif
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_chan,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_div
);

  // Config handshake: a write transfers on an edge where cfg_wr && cfg_ready;
  // cfg_wr without cfg_ready is dropped with no side effect and is not held.
  logic [NUM_CH-1:0] wr_sel;

  // Out-of-range channel numbers match no slot and so leave cfg_ready low.
  always_comb begin
    cfg_ready = 1'b0;
    wr_sel    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_chan == CH_W'(i)) begin
        cfg_ready = !pending[i];
        wr_sel[i] = cfg_wr && !pending[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    frac_phase_acc #(
      .ACC_W       (ACC_W),
      .DEFAULT_INC (DEFAULT_INC)
    ) u_acc (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (chan_en[g]),
`ifdef FRAC_CLOCK_GEN_PHASE_SYNC_EN
      .sync    (sync),
`endif
      .wr      (wr_sel[g]),
      .wr_inc  (cfg_inc),
      .tick    (tick[g]),
      .clk_div (clk_div[g]),
      .pending (pending[g])
    );
  end

endmodule

// File: tb/tb_frac_clock_gen.sv
// Self-checking bench for frac_clock_gen: reference model feeds an expected
// queue of {pending, tick, clk_div}, plus directed checks per scenario.
module tb_frac_clock_gen;
  import frac_clk_pkg::*;

  localparam int NUM = 5;
  localparam int AW  = ACC_W_DEF;
  localparam int CW  = 3;
  localparam int VW  = 3 * NUM;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NUM-1:0] chan_en = '1;
  logic           cfg_wr = 1'b0;
  logic [CW-1:0]  cfg_chan = '0;
  logic [AW-1:0]  cfg_inc = '0;
  logic           cfg_ready;
  logic [NUM-1:0] pending, tick, clk_div;
`ifdef FRAC_CLOCK_GEN_PHASE_SYNC_EN
  logic           sync = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] exp_v, got_v;

  logic [AW-1:0] m_acc[NUM];
  logic [AW-1:0] m_inc[NUM];
  logic [AW-1:0] m_sh[NUM];
  logic          m_pend[NUM];

  always #10 clk = ~clk;

  frac_clock_gen #(.NUM_CH(NUM), .ACC_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .chan_en   (chan_en),
`ifdef FRAC_CLOCK_GEN_PHASE_SYNC_EN
    .sync      (sync),
`endif
    .cfg_wr    (cfg_wr),
    .cfg_chan  (cfg_chan),
    .cfg_inc   (cfg_inc),
    .cfg_ready (cfg_ready),
    .pending   (pending),
    .tick      (tick),
    .clk_div   (clk_div)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int c = 0; c < NUM; c++) begin
      m_acc[c]  = '0;
      m_inc[c]  = AW'(default_inc(AW));
      m_sh[c]   = '0;
      m_pend[c] = 1'b0;
    end
  endtask

  // Advance the model with the currently driven inputs, queue the expected
  // outputs, then move to 1 time unit after the next rising edge.
  task automatic step();
    logic [NUM-1:0] e_pend, e_tick, e_div;
    logic [AW:0]    s;
    logic           sync_now;
    logic           wr_c, apply;
`ifdef FRAC_CLOCK_GEN_PHASE_SYNC_EN
    sync_now = sync;
`else
    sync_now = 1'b0;
`endif
    for (int c = 0; c < NUM; c++) begin
      wr_c  = cfg_wr && (int'(cfg_chan) == c) && !m_pend[c];
      apply = 1'b0;
      if (!chan_en[c] || sync_now) begin
        e_tick[c] = 1'b0;
        m_acc[c]  = '0;
        apply     = m_pend[c];
      end else begin
        s         = {1'b0, m_acc[c]} + {1'b0, m_inc[c]};
        e_tick[c] = s[AW];
        m_acc[c]  = s[AW-1:0];
        apply     = m_pend[c] && (s[AW] || m_inc[c] == '0);
      end
      if (apply) begin
        m_inc[c]  = m_sh[c];
        m_pend[c] = 1'b0;
      end
      if (wr_c) begin
        m_sh[c]   = cfg_inc;
        m_pend[c] = 1'b1;
      end
      e_pend[c] = m_pend[c];
      e_div[c]  = m_acc[c][AW-1];
    end
    exp_q.push_back({e_pend, e_tick, e_div});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    chan_en = '1;
    #35;
    vectors++;
    if ({pending, tick, clk_div} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0", {pending, tick, clk_div});
    end
    vectors++;
    if (cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b expected 1", cfg_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_div2();
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_v = exp_q.pop_front();
      got_v = {pending, tick, clk_div};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL div2_sb cyc %0d: got %h expected %h", k, got_v, exp_v);
      end
      vectors++;
      if (tick !== ((k % 2 == 0) ? '1 : '0) || clk_div !== ((k % 2 == 1) ? '1 : '0)) begin
        miscompares++;
        $display("FAIL div2_pattern cyc %0d: tick %b clk_div %b", k, tick, clk_div);
      end
    end
  endtask

  task automatic test_inc_update();
    int t1, t0;
    vectors++;
    if (cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL upd_ready: got %b expected 1", cfg_ready);
    end
    cfg_wr = 1'b1; cfg_chan = 3'd1; cfg_inc = AW'(inc_for_ratio(AW, 1, 4));
    step();
    cfg_wr = 1'b0;
    exp_v = exp_q.pop_front();
    got_v = {pending, tick, clk_div};
    vectors++;
    if (got_v !== exp_v) begin
      miscompares++;
      $display("FAIL upd_sb_write: got %h expected %h", got_v, exp_v);
    end
    vectors++;
    if (pending !== 5'b00010) begin
      miscompares++;
      $display("FAIL upd_pending_set: got %b expected 00010", pending);
    end
    step();
    exp_v = exp_q.pop_front();
    got_v = {pending, tick, clk_div};
    vectors++;
    if (got_v !== exp_v || pending !== '0 || tick[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL upd_apply: got %h expected %h (pending 0, tick1 1)", got_v, exp_v);
    end
    t1 = 0; t0 = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      exp_v = exp_q.pop_front();
      got_v = {pending, tick, clk_div};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL upd_sb cyc %0d: got %h expected %h", k, got_v, exp_v);
      end
      t1 += int'(tick[1]);
      t0 += int'(tick[0]);
    end
    vectors++;
    if (t1 != 2 || t0 != 4) begin
      miscompares++;
      $display("FAIL upd_rates: ch1 ticks %0d expected 2, ch0 ticks %0d expected 4", t1, t0);
    end
  endtask

  task automatic test_drop();
    int n, t1;
    cfg_wr = 1'b1; cfg_chan = 3'd1; cfg_inc = 16'h2000;
    step();
    exp_v = exp_q.pop_front();
    got_v = {pending, tick, clk_div};
    vectors++;
    if (got_v !== exp_v) begin
      miscompares++;
      $display("FAIL drop_sb_first: got %h expected %h", got_v, exp_v);
    end
    cfg_inc = 16'h1000;
    #1;
    vectors++;
    if (cfg_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_ready: got %b expected 0", cfg_ready);
    end
    step();
    cfg_wr = 1'b0;
    exp_v = exp_q.pop_front();
    got_v = {pending, tick, clk_div};
    vectors++;
    if (got_v !== exp_v) begin
      miscompares++;
      $display("FAIL drop_sb_second: got %h expected %h", got_v, exp_v);
    end
    n = 0;
    while (pending[1] !== 1'b0 && n < 8) begin
      step();
      exp_v = exp_q.pop_front();
      got_v = {pending, tick, clk_div};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL drop_sb_wait: got %h expected %h", got_v, exp_v);
      end
      n++;
    end
    vectors++;
    if (pending[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_apply_timeout: pending1 %b expected 0", pending[1]);
    end
    t1 = 0;
    for (int k = 0; k < 32; k++) begin
      step();
      exp_v = exp_q.pop_front();
      got_v = {pending, tick, clk_div};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL drop_sb cyc %0d: got %h expected %h", k, got_v, exp_v);
      end
      t1 += int'(tick[1]);
    end
    vectors++;
    if (t1 != 4) begin
      miscompares++;
      $display("FAIL drop_rate: ch1 ticks %0d expected 4", t1);
    end
  endtask

  task automatic test_out_of_range();
    for (int c = 5; c <= 7; c++) begin
      cfg_wr = 1'b1; cfg_chan = CW'(c); cfg_inc = 16'h1234;
      #1;
      vectors++;
      if (cfg_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL oor_ready chan %0d: got %b expected 0", c, cfg_ready);
      end
      step();
      exp_v = exp_q.pop_front();
      got_v = {pending, tick, clk_div};
      vectors++;
      if (got_v !== exp_v || pending !== '0) begin
        miscompares++;
        $display("FAIL oor_sb chan %0d: got %h expected %h", c, got_v, exp_v);
      end
    end
    cfg_wr = 1'b0;
  endtask

  task automatic test_disable();
    int t3;
    cfg_wr = 1'b1; cfg_chan = 3'd3; cfg_inc = 16'h4000;
    step();
    cfg_wr = 1'b0;
    exp_v = exp_q.pop_front();
    got_v = {pending, tick, clk_div};
    vectors++;
    if (got_v !== exp_v || pending[3] !== 1'b1) begin
      miscompares++;
      $display("FAIL dis_write: got %h expected %h", got_v, exp_v);
    end
    chan_en[3] = 1'b0;
    step();
    exp_v = exp_q.pop_front();
    got_v = {pending, tick, clk_div};
    vectors++;
    if (got_v !== exp_v || pending[3] !== 1'b0 || tick[3] !== 1'b0 || clk_div[3] !== 1'b0) begin
      miscompares++;
      $display("FAIL dis_off: got %h expected %h", got_v, exp_v);
    end
    chan_en[3] = 1'b1;
    t3 = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      exp_v = exp_q.pop_front();
      got_v = {pending, tick, clk_div};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL dis_sb cyc %0d: got %h expected %h", k, got_v, exp_v);
      end
      t3 += int'(tick[3]);
    end
    vectors++;
    if (t3 != 2) begin
      miscompares++;
      $display("FAIL dis_rate: ch3 ticks %0d expected 2", t3);
    end
  endtask

  task automatic test_ratio();
    int n, t2;
    cfg_wr = 1'b1; cfg_chan = 3'd2; cfg_inc = 16'h80E5;
    step();
    cfg_wr = 1'b0;
    void'(exp_q.pop_front());
    n = 0;
    while (pending[2] !== 1'b0 && n < 4) begin
      step();
      void'(exp_q.pop_front());
      n++;
    end
    vectors++;
    if (pending[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL ratio_apply_timeout: pending2 %b expected 0", pending[2]);
    end
    t2 = 0;
    for (int k = 0; k < 65536; k++) begin
      step();
      exp_v = exp_q.pop_front();
      got_v = {pending, tick, clk_div};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL ratio_sb cyc %0d: got %h expected %h", k, got_v, exp_v);
      end
      t2 += int'(tick[2]);
    end
    vectors++;
    if (t2 < 32'h80E5 - 1 || t2 > 32'h80E5 + 1) begin
      miscompares++;
      $display("FAIL ratio_count: ch2 ticks %0d expected %0d +-1", t2, 32'h80E5);
    end
  endtask

  task automatic test_async_reset();
    cfg_wr = 1'b1; cfg_chan = 3'd0; cfg_inc = 16'h1000;
    step();
    cfg_wr = 1'b0;
    void'(exp_q.pop_front());
    #5;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({pending, tick, clk_div} !== '0) begin
      miscompares++;
      $display("FAIL areset_outputs: got %h expected 0", {pending, tick, clk_div});
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int k = 1; k <= 4; k++) begin
      step();
      exp_v = exp_q.pop_front();
      got_v = {pending, tick, clk_div};
      vectors++;
      if (got_v !== exp_v || tick[0] !== ((k % 2 == 0) ? 1'b1 : 1'b0)) begin
        miscompares++;
        $display("FAIL areset_div2 cyc %0d: got %h expected %h", k, got_v, exp_v);
      end
    end
  endtask

`ifdef FRAC_CLOCK_GEN_PHASE_SYNC_EN
  task automatic test_sync();
    chan_en[1] = 1'b0;
    step();
    void'(exp_q.pop_front());
    chan_en = '1;
    cfg_wr = 1'b1; cfg_chan = 3'd0; cfg_inc = 16'h2000;
    step();
    cfg_wr = 1'b0;
    void'(exp_q.pop_front());
    sync = 1'b1;
    step();
    sync = 1'b0;
    exp_v = exp_q.pop_front();
    got_v = {pending, tick, clk_div};
    vectors++;
    if (got_v !== exp_v || tick !== '0 || clk_div !== '0 || pending !== '0) begin
      miscompares++;
      $display("FAIL sync_pulse: got %h expected %h", got_v, exp_v);
    end
    for (int k = 0; k < 6; k++) begin
      step();
      exp_v = exp_q.pop_front();
      got_v = {pending, tick, clk_div};
      vectors++;
      if (got_v !== exp_v || (clk_div[4:1] != 4'h0 && clk_div[4:1] != 4'hf)) begin
        miscompares++;
        $display("FAIL sync_align cyc %0d: got %h expected %h", k, got_v, exp_v);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_div2();
    test_inc_update();
    test_drop();
    test_out_of_range();
    test_disable();
    test_ratio();
    test_async_reset();
`ifdef FRAC_CLOCK_GEN_PHASE_SYNC_EN
    test_sync();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
